fifo_drain_sram_wr: RTL and testbench
=====================================

# fifo_drain_sram_wr

Read-side controller for the depth-16 output FIFO. It pops words from the FIFO and writes them into one bank of a double-buffered result SRAM, for a burst length programmed per transaction. It sits between the MAC-array output FIFO and the output SRAM, and toggles the SRAM bank after each completed burst so the consumer can read the other bank.

## Interface
- bw, 11, bits per lane (matches FIFO)
- simd, 1, lanes per FIFO word
- addr_w, 6, word-address width within one bank (bank depth 2^addr_w)

- clk  in  1  single clock; FIFO rd side and SRAM run on it
- reset_n  in  1  synchronous, active-low reset
- start  in  1  burst request; sampled only in IDLE
- num_words  in  addr_w+1  burst length, sampled with start; 0 allowed
- base_addr  in  addr_w  first word address within bank, sampled with start
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  simd*bw  FIFO head word (combinational from FIFO rd pointer)
- fifo_rd  out  1  pop strobe to FIFO
- sram_ready  in  1  high in cycle N: SRAM accepts a write presented in cycle N+1
- sram_wen  out  1  write strobe, active-high, registered
- sram_addr  out  addr_w+1  {bank, word address}, registered
- sram_din  out  simd*bw  write data, registered
- bank  out  1  bank currently being written; consumer reads ~bank
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE, DRAIN, LAST.
- IDLE: start=1 latches num_words, base_addr; remaining<=num_words, idx<=0. num_words!=0 -> DRAIN; num_words==0 -> LAST (no write). start in other states ignored.
- DRAIN: fifo_rd = !fifo_empty && sram_ready && remaining!=0 (combinational). On a pop: sram_din<=fifo_data, sram_addr<={bank, base_addr+idx}, sram_wen<=1, idx+1, remaining-1; otherwise sram_wen<=0. Pop that leaves remaining==0 -> LAST.
- LAST: done=1, busy=1; sram_wen carries the final write (0 for empty burst). Next state IDLE; bank toggles at end of LAST only if ≥1 word written.
- Address arithmetic: base_addr+idx modulo 2^addr_w; wraps within bank, never crosses into other bank.
- fifo_rd is never asserted while fifo_empty=1; FIFO stall (empty) or SRAM stall (sram_ready=0) holds idx/remaining and drops sram_wen next cycle.
- busy = (state!=IDLE); done = (state==LAST).

## Timing
- Reset (reset_n=0 at edge): state IDLE, fifo_rd 0, sram_wen 0, sram_addr 0, sram_din 0, bank 0, busy 0, done 0; reset mid-burst drops any pending write and returns bank to 0.
- start accepted in cycle 0 -> busy=1 from cycle 1; earliest pop cycle 1.
- Pop-to-write latency: exactly 1 cycle.
- N words, no stalls: pops cycles 1..N, sram_wen cycles 2..N+1, done cycle N+1 (with last write), IDLE cycle N+2; next start accepted from cycle N+2.
- num_words=0: done in cycle 1, no fifo_rd, no sram_wen, bank unchanged.
- Throughput: one word per cycle while FIFO non-empty and sram_ready=1.

## Configuration
- DBUF_SWAP_EN defined: bank toggles after each non-empty burst as above.
- DBUF_SWAP_EN undefined: bank tied to 0; sram_addr MSB always 0; all other behaviour identical.

## Structure
- Shared package fifo_drain_pkg: state encoding constants (IDLE, DRAIN, LAST) and default widths.
- One sub-module: fifo_drain_addr_gen (idx/remaining counters, wrap add, bank register).

## Test plan
- Reset, FIFO preloaded with 4 words 0x001..0x004, start num_words=4 base_addr=0 -> writes addr 0..3 data 0x001..0x004 cycles 2..5, done cycle 5, bank=1 after.
- FIFO empty for cycles 2-3 mid-burst -> fifo_rd and sram_wen gap exactly matches empty window, no duplicate/lost words.
- sram_ready=0 for 2 cycles during 8-word burst -> no pops during low cycles; addresses stay contiguous; 8 writes total.
- base_addr=62, num_words=4, addr_w=6 -> word addresses 62,63,0,1 with bank MSB unchanged.
- start num_words=0 -> done in cycle 1, no fifo_rd/sram_wen, bank unchanged; start while busy ignored.
- reset_n=0 after 3 of 8 writes -> all outputs zero next cycle, bank 0; new 2-word burst completes normally.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared constants for the FIFO-drain / SRAM-write controller: default widths
// and the FSM state encoding.
package fifo_drain_pkg;

    localparam int unsigned BW_DEF     = 11;
    localparam int unsigned SIMD_DEF   = 1;
    localparam int unsigned ADDR_W_DEF = 6;

    localparam int unsigned ST_W = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LAST  = 2'd2;

endpackage

// File: rtl/fifo_drain_addr_gen.sv
// Burst bookkeeping: word index / remaining-count counters, in-bank wrapping
// address add, and the double-buffer bank register.
// Optional feature macro: DBUF_SWAP_EN (bank toggles after each non-empty
// burst); when undefined the bank is tied to 0.
module fifo_drain_addr_gen
    import fifo_drain_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [ADDR_W:0]   i_num_words,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_pop,
    input  logic              i_swap,
    output logic              o_rem_nz_c,
    output logic              o_last_c,
    output logic              o_written_c,
    output logic [ADDR_W-1:0] o_word_addr_c,
    output logic              o_bank
);

    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W-1:0] r_base;
    logic              r_bank;

    // Latch burst parameters on start; advance index / remaining on each pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_idx  <= '0;
            r_rem  <= '0;
            r_base <= '0;
        end else if (i_load) begin
            r_idx  <= '0;
            r_rem  <= i_num_words;
            r_base <= i_base_addr;
        end else if (i_pop) begin
            r_idx  <= r_idx + (ADDR_W+1)'(1);
            r_rem  <= r_rem - (ADDR_W+1)'(1);
        end
    end

`ifdef DBUF_SWAP_EN
    // Flip the bank once a burst that wrote at least one word completes.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_bank <= 1'b0;
        end else if (i_swap) begin
            r_bank <= ~r_bank;
        end
    end
`else
    logic w_unused_swap;
    assign w_unused_swap = i_swap;
    assign r_bank        = 1'b0;
`endif

    // Address wraps modulo 2^ADDR_W inside the bank by construction of the width.
    assign o_word_addr_c = r_base + r_idx[ADDR_W-1:0];
    assign o_rem_nz_c    = (r_rem != '0);
    assign o_last_c      = (r_rem == (ADDR_W+1)'(1));
    assign o_written_c   = (r_idx != '0);
    assign o_bank        = r_bank;

endmodule

// File: rtl/fifo_drain_sram_wr.sv
// Read-side controller of the output FIFO: pops words and writes them into
// one bank of the double-buffered result SRAM for a programmed burst length.
// Optional feature macro: DBUF_SWAP_EN (bank swap after each non-empty burst).
module fifo_drain_sram_wr
    import fifo_drain_pkg::*;
#(
    parameter int unsigned BW     = BW_DEF,
    parameter int unsigned SIMD   = SIMD_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [ADDR_W:0]      i_num_words,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic                 i_fifo_empty,
    input  logic [SIMD*BW-1:0]   i_fifo_data,
    output logic                 o_fifo_rd,
    input  logic                 i_sram_ready,
    output logic                 o_sram_wen,
    output logic [ADDR_W:0]      o_sram_addr,
    output logic [SIMD*BW-1:0]   o_sram_din,
    output logic                 o_bank,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned DW = SIMD * BW;

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic              w_load;
    logic              w_pop;
    logic              w_swap;

    logic              w_rem_nz;
    logic              w_last;
    logic              w_written;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_bank;

    logic              r_sram_wen;
    logic [ADDR_W:0]   r_sram_addr;
    logic [DW-1:0]     r_sram_din;
    logic              r_busy;
    logic              r_done;

    fifo_drain_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_load        (w_load),
        .i_num_words   (i_num_words),
        .i_base_addr   (i_base_addr),
        .i_pop         (w_pop),
        .i_swap        (w_swap),
        .o_rem_nz_c    (w_rem_nz),
        .o_last_c      (w_last),
        .o_written_c   (w_written),
        .o_word_addr_c (w_word_addr),
        .o_bank        (w_bank)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus pop / load / bank-swap strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (i_num_words == '0) ? S_LAST : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_pop = !i_fifo_empty && i_sram_ready && w_rem_nz;
                if (w_pop && w_last) begin
                    w_state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                w_swap      = w_written;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SRAM write port and status flags, one cycle behind the pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sram_wen  <= 1'b0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sram_wen <= w_pop;
            if (w_pop) begin
                r_sram_addr <= {w_bank, w_word_addr};
                r_sram_din  <= i_fifo_data;
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_LAST);
        end
    end

    assign o_fifo_rd   = w_pop;
    assign o_sram_wen  = r_sram_wen;
    assign o_sram_addr = r_sram_addr;
    assign o_sram_din  = r_sram_din;
    assign o_bank      = w_bank;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_fifo_drain_sram_wr.sv
// Self-checking bench for fifo_drain_sram_wr. A queue models the FIFO; each
// burst's expected writes, pop cycles and completion cycle are derived from
// the burst length, base address and stall windows.
// Honours DBUF_SWAP_EN for the expected bank behaviour.
module tb_fifo_drain_sram_wr;

    localparam int unsigned BW     = 11;
    localparam int unsigned SIMD   = 1;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DW     = SIMD * BW;
`ifdef DBUF_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic              i_start;
    logic [ADDR_W:0]   i_num_words;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_fifo_empty;
    logic [DW-1:0]     i_fifo_data;
    logic              o_fifo_rd;
    logic              i_sram_ready;
    logic              o_sram_wen;
    logic [ADDR_W:0]   o_sram_addr;
    logic [DW-1:0]     o_sram_din;
    logic              o_bank;
    logic              o_busy;
    logic              o_done;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_bank = 1'b0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    fifo_drain_sram_wr dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_num_words  (i_num_words),
        .i_base_addr  (i_base_addr),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_rd    (o_fifo_rd),
        .i_sram_ready (i_sram_ready),
        .o_sram_wen   (o_sram_wen),
        .o_sram_addr  (o_sram_addr),
        .o_sram_din   (o_sram_din),
        .o_bank       (o_bank),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    function automatic bit mbit(input logic [63:0] m, input int k);
        return (k >= 0 && k < 64) ? m[k] : 1'b0;
    endfunction

    // One burst: cycle 0 is the start cycle; returns after the done cycle
    // (or after abort_wr writes when abort_wr > 0).
    task automatic run_burst(input int n, input int base, input logic [63:0] emask,
                             input logic [63:0] rmask, input bit seq, input int abort_wr,
                             input string name);
        logic [DW-1:0]   words[$];
        logic [ADDR_W:0] ea;
        int exp_done, cnt, c, popped, widx;
        bit rd_exp, prev_rd, e_empty, rdy, aborted;
        words.delete();
        q.delete();
        for (int i = 0; i < n; i++) begin
            words.push_back(seq ? DW'(i + 1) : DW'($urandom));
            q.push_back(words[i]);
        end
        exp_done = (n == 0) ? 1 : 0;
        cnt = 0;
        for (int k = 1; k < 400 && exp_done == 0; k++) begin
            if (!mbit(emask, k) && !mbit(rmask, k)) begin
                cnt++;
                if (cnt == n) exp_done = k + 1;
            end
        end
        c = 0; popped = 0; widx = 0; prev_rd = 1'b0; aborted = 1'b0;
        forever begin
            @(negedge clk);
            i_start     = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_num_words = (c == 0) ? (ADDR_W+1)'(n) : (ADDR_W+1)'($urandom);
            i_base_addr = (c == 0) ? ADDR_W'(base) : ADDR_W'($urandom);
            e_empty      = (q.size() == 0) || mbit(emask, c);
            rdy          = !mbit(rmask, c);
            i_fifo_empty = e_empty;
            i_fifo_data  = (q.size() != 0) ? q[0] : DW'($urandom);
            i_sram_ready = rdy;
            #2;
            rd_exp = (c >= 1) && (popped < n) && !e_empty && rdy;
            n_cmp++;
            if (o_fifo_rd !== rd_exp) begin
                n_err++;
                $display("FAIL %s fifo_rd cyc%0d: got %b exp %b", name, c, o_fifo_rd, rd_exp);
            end
            n_cmp++;
            if (o_sram_wen !== prev_rd) begin
                n_err++;
                $display("FAIL %s sram_wen cyc%0d: got %b exp %b", name, c, o_sram_wen, prev_rd);
            end
            if (o_sram_wen === 1'b1) begin
                n_cmp++;
                if (widx >= n) begin
                    n_err++;
                    $display("FAIL %s extra write cyc%0d: got addr %h exp none", name, c, o_sram_addr);
                end else begin
                    ea = {1'(exp_bank), ADDR_W'((base + widx) % (1 << ADDR_W))};
                    if (o_sram_addr !== ea || o_sram_din !== words[widx]) begin
                        n_err++;
                        $display("FAIL %s write%0d: got addr %h data %h exp addr %h data %h",
                                 name, widx, o_sram_addr, o_sram_din, ea, words[widx]);
                    end
                end
                widx++;
            end
            n_cmp++;
            if (o_done !== (c == exp_done) || o_busy !== (c >= 1) || o_bank !== exp_bank) begin
                n_err++;
                $display("FAIL %s status cyc%0d: got done %b busy %b bank %b exp %b %b %b",
                         name, c, o_done, o_busy, o_bank, (c == exp_done), (c >= 1), exp_bank);
            end
            if (o_fifo_rd === 1'b1 && q.size() != 0) void'(q.pop_front());
            if (rd_exp) popped++;
            prev_rd = rd_exp;
            if (abort_wr > 0 && widx >= abort_wr) begin
                aborted = 1'b1;
                break;
            end
            if (c >= exp_done) break;
            c++;
        end
        if (!aborted) begin
            if (SWAP && n != 0) exp_bank = ~exp_bank;
            @(negedge clk);
            i_start = 1'b0; i_fifo_empty = 1'b1; i_sram_ready = 1'b1;
            #2;
            n_cmp++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_sram_wen !== 1'b0 ||
                o_fifo_rd !== 1'b0 || o_bank !== exp_bank || widx != n) begin
                n_err++;
                $display("FAIL %s idle-after: got busy %b done %b wen %b rd %b bank %b writes %0d exp 0 0 0 0 %b %0d",
                         name, o_busy, o_done, o_sram_wen, o_fifo_rd, o_bank, widx, exp_bank, n);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if (o_fifo_rd !== 1'b0 || o_sram_wen !== 1'b0 || o_sram_addr !== '0 || o_sram_din !== '0 ||
            o_bank !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got rd %b wen %b addr %h din %h bank %b busy %b done %b exp all 0",
                     name, o_fifo_rd, o_sram_wen, o_sram_addr, o_sram_din, o_bank, o_busy, o_done);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_start = 1'b0; i_num_words = '0; i_base_addr = '0;
        i_fifo_empty = 1'b1; i_fifo_data = '0; i_sram_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_all_zero("reset");
        i_reset_n = 1'b1;
        exp_bank = 1'b0;
    endtask

    task automatic test_basic();
        run_burst(4, 0, 64'd0, 64'd0, 1'b1, 0, "basic4");
    endtask

    task automatic test_fifo_empty_gap();
        run_burst(4, 5, 64'h0C, 64'd0, 1'b0, 0, "empty_gap");
    endtask

    task automatic test_sram_stall();
        run_burst(8, 17, 64'd0, 64'h18, 1'b0, 0, "sram_stall");
    endtask

    task automatic test_wrap();
        run_burst(4, 62, 64'd0, 64'd0, 1'b0, 0, "wrap");
    endtask

    task automatic test_zero_len();
        run_burst(0, 9, 64'd0, 64'd0, 1'b0, 0, "zero_len");
    endtask

    task automatic test_back_to_back();
        run_burst(3, 40, 64'd0, 64'd0, 1'b0, 0, "b2b_a");
        run_burst(5, 61, 64'd0, 64'd0, 1'b0, 0, "b2b_b");
    endtask

    task automatic test_random();
        logic [63:0] em, rm;
        for (int t = 0; t < 8; t++) begin
            em = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            rm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            run_burst($urandom_range(0, 20), $urandom_range(0, 63), em, rm, 1'b0, 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        run_burst(8, 30, 64'd0, 64'd0, 1'b0, 3, "mid_pre");
        q.delete();
        @(negedge clk);
        i_reset_n = 1'b0; i_start = 1'b0; i_fifo_empty = 1'b1;
        @(negedge clk);
        #2;
        check_all_zero("reset_mid");
        i_reset_n = 1'b1;
        exp_bank = 1'b0;
        run_burst(2, 7, 64'd0, 64'd0, 1'b0, 0, "mid_post");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_empty_gap();
        test_sram_stall();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
